// File: rtl/credit_display_encoder.sv
// Converts a 14-bit credit/price amount into four active-low 7-segment digit patterns
// using a sequential double-dabble conversion followed by a single encode cycle.
module credit_display_encoder (
   input  logic        clk,
   input  logic        reset,
   input  logic [13:0] value,
   input  logic        load,
   input  logic        blank_lz,
   output logic        busy,
   output logic        done,
   output logic [6:0]  seg0,
   output logic [6:0]  seg1,
   output logic [6:0]  seg2,
   output logic [6:0]  seg3
);

   localparam logic [6:0] SegBlank = 7'b1111111;
   localparam logic [6:0] SegDash  = 7'b1111110;
   localparam logic [3:0] LastShift = 4'd13;

   typedef enum logic [1:0] {StIdle, StConvert, StEncode} state_t;

   state_t            state_q, state_d;
   logic [13:0]       bin_q, bin_d;
   logic [15:0]       bcd_q, bcd_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              blank_q, blank_d;
   logic              ovf_q, ovf_d;
   logic              done_q, done_d;
   logic [3:0][6:0]   seg_q, seg_d;
   logic [15:0]       bcd_adj;
   logic              leading;

   // Segment order is {a,b,c,d,e,f,g}, a lit segment is 0.
   function automatic logic [6:0] digit_seg(input logic [3:0] d);
      logic [6:0] s;
      unique case (d)
         4'd0:    s = 7'b0000001;
         4'd1:    s = 7'b1001111;
         4'd2:    s = 7'b0010010;
         4'd3:    s = 7'b0000110;
         4'd4:    s = 7'b1001100;
         4'd5:    s = 7'b0100100;
         4'd6:    s = 7'b0100000;
         4'd7:    s = 7'b0001111;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0000100;
         default: s = SegDash;
      endcase
      return s;
   endfunction

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         if (bcd_q[i*4 +: 4] >= 4'd5) begin
            bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
         end else begin
            bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      blank_d = blank_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;
      seg_d   = seg_q;
      leading = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (load) begin
               bin_d   = value;
               blank_d = blank_lz;
               ovf_d   = (value > 14'd9999);
               bcd_d   = '0;
               cnt_d   = '0;
               state_d = StConvert;
            end
         end
         StConvert: begin
            {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == LastShift) begin
               state_d = StEncode;
            end
         end
         StEncode: begin
            // Blank zeros from the left until the first nonzero digit; digit0 always shows.
            leading = blank_q;
            for (int i = 3; i >= 1; i--) begin
               if (leading && (bcd_q[i*4 +: 4] == 4'd0)) begin
                  seg_d[i] = SegBlank;
               end else begin
                  leading  = 1'b0;
                  seg_d[i] = digit_seg(bcd_q[i*4 +: 4]);
               end
            end
            seg_d[0] = digit_seg(bcd_q[3:0]);
            if (ovf_q) begin
               seg_d = {4{SegDash}};
            end
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         bin_q   <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         blank_q <= 1'b0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
         seg_q   <= {4{SegBlank}};
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         blank_q <= blank_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
         seg_q   <= seg_d;
      end
   end

   assign busy = (state_q != StIdle);
   assign done = done_q;
   assign seg0 = seg_q[0];
   assign seg1 = seg_q[1];
   assign seg2 = seg_q[2];
   assign seg3 = seg_q[3];

endmodule

// File: tb/tb_credit_display_encoder.sv
// Directed-vector bench for credit_display_encoder with hand-computed segment patterns.
module tb_credit_display_encoder;

   localparam logic [6:0] S0 = 7'b0000001;
   localparam logic [6:0] S1 = 7'b1001111;
   localparam logic [6:0] S2 = 7'b0010010;
   localparam logic [6:0] S3 = 7'b0000110;
   localparam logic [6:0] S4 = 7'b1001100;
   localparam logic [6:0] S5 = 7'b0100100;
   localparam logic [6:0] S7 = 7'b0001111;
   localparam logic [6:0] S9 = 7'b0000100;
   localparam logic [6:0] SB = 7'b1111111;
   localparam logic [6:0] SD = 7'b1111110;

   logic        clk = 1'b0;
   logic        reset;
   logic [13:0] value;
   logic        load;
   logic        blank_lz;
   logic        busy;
   logic        done;
   logic [6:0]  seg0, seg1, seg2, seg3;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [27:0] last_exp;

   credit_display_encoder dut (
      .clk      (clk),
      .reset    (reset),
      .value    (value),
      .load     (load),
      .blank_lz (blank_lz),
      .busy     (busy),
      .done     (done),
      .seg0     (seg0),
      .seg1     (seg1),
      .seg2     (seg2),
      .seg3     (seg3)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [27:0] segs();
      return {seg3, seg2, seg1, seg0};
   endfunction

   // Called at a negedge; the following posedge samples the load.
   task automatic pulse_load(input logic [13:0] v, input logic b);
      value    = v;
      blank_lz = b;
      load     = 1'b1;
      @(negedge clk);
      load     = 1'b0;
      value    = 14'($urandom);
      blank_lz = 1'($urandom);
   endtask

   // Entered just after edge 1 (the load-sampling edge). Returns after the edge raising done.
   task automatic wait_done(input string tag, input int poke_edge, input logic [27:0] exp);
      int edge_n   = 1;
      int busy_cnt = 0;
      logic hold_ok = 1'b1;
      for (int i = 0; i < 40 && !done; i++) begin
         if (busy) busy_cnt++;
         if (segs() !== last_exp) hold_ok = 1'b0;
         if (edge_n == poke_edge) begin
            value = 14'd77;
            load  = 1'b1;
         end else begin
            load  = 1'b0;
         end
         @(negedge clk);
         edge_n++;
      end
      load = 1'b0;
      check({tag, " done_edge"}, edge_n, 16);
      check({tag, " busy_cycles"}, busy_cnt, 15);
      check({tag, " seg_hold"}, hold_ok, 1);
      check({tag, " busy_at_done"}, busy, 0);
      check({tag, " segs"}, segs(), exp);
      last_exp = exp;
   endtask

   task automatic convert(input string tag, input logic [13:0] v, input logic b,
                          input logic [27:0] exp);
      @(negedge clk);
      pulse_load(v, b);
      wait_done(tag, 0, exp);
      @(negedge clk);
      check({tag, " done_one_cycle"}, done, 0);
   endtask

   initial begin
      int dones;
      reset    = 1'b1;
      load     = 1'b0;
      value    = '0;
      blank_lz = 1'b0;
      last_exp = {4{SB}};
      repeat (3) @(negedge clk);
      check("reset segs", segs(), {4{SB}});
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      reset = 1'b0;

      convert("v1234", 14'd1234, 1'b0, {S1, S2, S3, S4});
      convert("v50_blank", 14'd50, 1'b1, {SB, SB, S5, S0});
      convert("v50_noblank", 14'd50, 1'b0, {S0, S0, S5, S0});
      convert("v0_blank", 14'd0, 1'b1, {SB, SB, SB, S0});
      convert("v9999", 14'd9999, 1'b0, {4{S9}});
      convert("v105_blank", 14'd105, 1'b1, {SB, S1, S0, S5});
      convert("v12000", 14'd12000, 1'b1, {4{SD}});
      convert("v10000", 14'd10000, 1'b0, {4{SD}});

      // Load while busy is ignored, then reload in the done cycle.
      @(negedge clk);
      pulse_load(14'd42, 1'b0);
      wait_done("v42_ignore77", 5, {S0, S0, S4, S2});
      pulse_load(14'd77, 1'b1);
      check("done_cycle_reload done_low", done, 0);
      check("done_cycle_reload busy", busy, 1);
      wait_done("v77_reload", 0, {SB, SB, S7, S7});

      // Reset at edge 8 of a conversion aborts it.
      @(negedge clk);
      pulse_load(14'd1234, 1'b0);
      repeat (6) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort segs", segs(), {4{SB}});
      check("abort busy", busy, 0);
      dones = 0;
      for (int i = 0; i < 20; i++) begin
         if (done) dones++;
         @(negedge clk);
      end
      check("abort no_done", dones, 0);
      last_exp = {4{SB}};

      convert("post_reset_9999", 14'd9999, 1'b1, {4{S9}});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
